// File: rtl/xor_checksum_accum.sv
// Streaming XOR checksum engine: folds up to FRAME_LEN words of WIDTH bits into one
// checksum and presents it with a valid/ready handshake on registered outputs.
module xor_checksum_accum #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned FRAME_LEN = 4,
  parameter int unsigned CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] out_count,
  output logic             out_parity
);

  typedef enum logic [0:0] {StAccum, StHold} state_e;

  localparam logic [CNT_W-1:0] FrameLenC = CNT_W'(FRAME_LEN);

  state_e           state_q;
  logic [WIDTH-1:0] acc_q;
  logic [CNT_W-1:0] cnt_q;

  logic             accept;
  logic             frame_close;
  logic [WIDTH-1:0] acc_nxt;
  logic [CNT_W-1:0] cnt_nxt;

  // Held low while reset is asserted so no word is offered as accepted during reset.
  assign in_ready = rst_n && (state_q == StAccum);

  always_comb begin
    accept      = in_valid && in_ready;
    acc_nxt     = acc_q ^ in_data;
    cnt_nxt     = cnt_q + CNT_W'(1);
    frame_close = in_last || (cnt_nxt == FrameLenC);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StAccum;
      acc_q      <= '0;
      cnt_q      <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_count  <= '0;
      out_parity <= 1'b0;
    end else begin
      unique case (state_q)
        StAccum: begin
          if (accept) begin
            if (frame_close) begin
              out_data   <= acc_nxt;
              out_count  <= cnt_nxt;
              out_parity <= ^acc_nxt;
              out_valid  <= 1'b1;
              acc_q      <= '0;
              cnt_q      <= '0;
              state_q    <= StHold;
            end else begin
              acc_q <= acc_nxt;
              cnt_q <= cnt_nxt;
            end
          end
        end
        StHold: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state_q   <= StAccum;
          end
        end
        default: state_q <= StAccum;
      endcase
    end
  end

endmodule

// File: tb/tb_xor_checksum_accum.sv
// Directed bench for xor_checksum_accum: three instances cover the default configuration,
// a 1-bit two-word frame (XOR truth table) and single-word frames.
module tb_xor_checksum_accum;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  // Instance A: WIDTH=8, FRAME_LEN=4
  logic       a_in_valid, a_in_ready, a_in_last, a_out_valid, a_out_ready, a_out_parity;
  logic [7:0] a_in_data, a_out_data, a_out_count;
  // Instance B: WIDTH=1, FRAME_LEN=2
  logic       b_in_valid, b_in_ready, b_in_last, b_out_valid, b_out_ready, b_out_parity;
  logic [0:0] b_in_data, b_out_data;
  logic [7:0] b_out_count;
  // Instance C: WIDTH=8, FRAME_LEN=1
  logic       c_in_valid, c_in_ready, c_in_last, c_out_valid, c_out_ready, c_out_parity;
  logic [7:0] c_in_data, c_out_data, c_out_count;

  xor_checksum_accum #(.WIDTH(8), .FRAME_LEN(4), .CNT_W(8)) u_a (
    .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_data(a_in_data), .in_last(a_in_last), .out_valid(a_out_valid),
    .out_ready(a_out_ready), .out_data(a_out_data), .out_count(a_out_count),
    .out_parity(a_out_parity)
  );

  xor_checksum_accum #(.WIDTH(1), .FRAME_LEN(2), .CNT_W(8)) u_b (
    .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_data(b_in_data), .in_last(b_in_last), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .out_data(b_out_data), .out_count(b_out_count),
    .out_parity(b_out_parity)
  );

  xor_checksum_accum #(.WIDTH(8), .FRAME_LEN(1), .CNT_W(8)) u_c (
    .clk(clk), .rst_n(rst_n), .in_valid(c_in_valid), .in_ready(c_in_ready),
    .in_data(c_in_data), .in_last(c_in_last), .out_valid(c_out_valid),
    .out_ready(c_out_ready), .out_data(c_out_data), .out_count(c_out_count),
    .out_parity(c_out_parity)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, then settle before sampling or driving.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_a(input string tag, input logic v, input logic [7:0] d,
                       input logic [7:0] c, input logic p);
    chk({tag, ".valid"}, 32'(a_out_valid), 32'(v));
    chk({tag, ".data"}, 32'(a_out_data), 32'(d));
    chk({tag, ".count"}, 32'(a_out_count), 32'(c));
    chk({tag, ".parity"}, 32'(a_out_parity), 32'(p));
  endtask

  task automatic send_a(input logic [7:0] d, input logic last);
    a_in_valid = 1'b1;
    a_in_data  = d;
    a_in_last  = last;
    tick();
    a_in_valid = 1'b0;
    a_in_last  = 1'b0;
  endtask

  task automatic send_b(input logic d);
    b_in_valid = 1'b1;
    b_in_data  = d;
    tick();
    b_in_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    a_in_valid = 1'b0; a_in_data = '0; a_in_last = 1'b0; a_out_ready = 1'b1;
    b_in_valid = 1'b0; b_in_data = '0; b_in_last = 1'b0; b_out_ready = 1'b1;
    c_in_valid = 1'b0; c_in_data = '0; c_in_last = 1'b0; c_out_ready = 1'b1;

    // Reset state
    tick();
    tick();
    chk_a("reset", 1'b0, 8'h00, 8'd0, 1'b0);
    chk("reset.in_ready", 32'(a_in_ready), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("post_reset.in_ready", 32'(a_in_ready), 32'd1);

    // Full-frame closure: 01^02^04^08 = 0F
    send_a(8'h01, 1'b0);
    send_a(8'h02, 1'b0);
    send_a(8'h04, 1'b0);
    chk("full.mid_valid", 32'(a_out_valid), 32'd0);
    send_a(8'h08, 1'b0);
    chk_a("full", 1'b1, 8'h0F, 8'd4, 1'b0);
    chk("full.hold_in_ready", 32'(a_in_ready), 32'd0);
    tick();
    chk("full.release_valid", 32'(a_out_valid), 32'd0);
    chk("full.release_in_ready", 32'(a_in_ready), 32'd1);

    // Early close: A5^5A = FF, then single word 80
    send_a(8'hA5, 1'b0);
    send_a(8'h5A, 1'b1);
    chk_a("early", 1'b1, 8'hFF, 8'd2, 1'b0);
    tick();
    send_a(8'h80, 1'b1);
    chk_a("early_next", 1'b1, 8'h80, 8'd1, 1'b1);
    tick();

    // Backpressure: result 0F held while 0x33 waits at the input
    a_out_ready = 1'b0;
    send_a(8'h01, 1'b0);
    send_a(8'h02, 1'b0);
    send_a(8'h04, 1'b0);
    send_a(8'h08, 1'b0);
    a_in_valid = 1'b1;
    a_in_data  = 8'h33;
    a_in_last  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk_a("bp.hold", 1'b1, 8'h0F, 8'd4, 1'b0);
      chk("bp.in_ready", 32'(a_in_ready), 32'd0);
      tick();
    end
    a_out_ready = 1'b1;
    tick();
    chk("bp.release_valid", 32'(a_out_valid), 32'd0);
    chk("bp.release_in_ready", 32'(a_in_ready), 32'd1);
    tick();
    a_in_valid = 1'b0;
    a_in_last  = 1'b0;
    chk_a("bp.after", 1'b1, 8'h33, 8'd1, 1'b0);
    tick();

    // Reset mid-frame discards the partial FF^FF accumulation
    send_a(8'hFF, 1'b0);
    send_a(8'hFF, 1'b0);
    rst_n = 1'b0;
    tick();
    chk_a("rst_mid", 1'b0, 8'h00, 8'd0, 1'b0);
    chk("rst_mid.in_ready", 32'(a_in_ready), 32'd0);
    rst_n = 1'b1;
    send_a(8'h11, 1'b0);
    send_a(8'h22, 1'b0);
    send_a(8'h44, 1'b0);
    send_a(8'h88, 1'b0);
    chk_a("rst_clean", 1'b1, 8'hFF, 8'd4, 1'b0);
    tick();

    // XOR truth table on a 1-bit, 2-word engine
    send_b(1'b0); send_b(1'b0);
    chk("tt00.data", 32'(b_out_data), 32'd0);
    chk("tt00.parity", 32'(b_out_parity), 32'd0);
    chk("tt00.count", 32'(b_out_count), 32'd2);
    tick();
    send_b(1'b0); send_b(1'b1);
    chk("tt01.data", 32'(b_out_data), 32'd1);
    chk("tt01.parity", 32'(b_out_parity), 32'd1);
    tick();
    send_b(1'b1); send_b(1'b0);
    chk("tt10.data", 32'(b_out_data), 32'd1);
    chk("tt10.parity", 32'(b_out_parity), 32'd1);
    tick();
    send_b(1'b1); send_b(1'b1);
    chk("tt11.data", 32'(b_out_data), 32'd0);
    chk("tt11.parity", 32'(b_out_parity), 32'd0);
    chk("tt11.valid", 32'(b_out_valid), 32'd1);
    tick();

    // Source gaps on a single-word-frame engine
    c_in_valid = 1'b1;
    c_in_data  = 8'h3C;
    tick();
    chk("gap1.valid", 32'(c_out_valid), 32'd1);
    chk("gap1.data", 32'(c_out_data), 32'h3C);
    chk("gap1.count", 32'(c_out_count), 32'd1);
    c_in_valid = 1'b0;
    c_in_data  = 8'hAA;
    tick();
    chk("gap.release_valid", 32'(c_out_valid), 32'd0);
    tick();
    chk("gap.idle_valid", 32'(c_out_valid), 32'd0);
    c_in_valid = 1'b1;
    c_in_data  = 8'hC3;
    tick();
    c_in_valid = 1'b0;
    chk("gap2.valid", 32'(c_out_valid), 32'd1);
    chk("gap2.data", 32'(c_out_data), 32'hC3);
    chk("gap2.count", 32'(c_out_count), 32'd1);
    chk("gap2.parity", 32'(c_out_parity), 32'd0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
